// File: rtl/sys_sram_pkg.sv
// Shared types and helpers for the APB system SRAM slave.
// Optional per-byte parity is enabled with SYS_SRAM_PARITY_EN.
package sys_sram_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int WCNT_W = 4;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

  function automatic int addr_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/sys_sram_bank.sv
// Word-wide SRAM bank: per-byte write enable, registered read port.
// Stores one even-parity bit per byte when SYS_SRAM_PARITY_EN is defined.
module sram_bank
  import sys_sram_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int IW    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      re,
  input  logic                      clr,
  input  logic [IW-1:0]             idx,
  input  logic [DW-1:0]             wdata,
  input  logic [bytes_per_word(DW)-1:0] stb,
`ifdef SYS_SRAM_PARITY_EN
  input  logic                      inj,
`endif
  output logic [DW-1:0]             rdata_o,
  output logic                      perr_o
);
  localparam int BPW = bytes_per_word(DW);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BPW; i++) begin
        if (stb[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Out-of-range accesses clear the read register instead of reading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rdata_q <= '0;
    else if (re)  rdata_q <= mem_q[idx];
    else if (clr) rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

`ifdef SYS_SRAM_PARITY_EN
  function automatic logic [BPW-1:0] byte_par(input logic [DW-1:0] w);
    byte_par = '0;
    for (int i = 0; i < BPW; i++) byte_par[i] = ^w[8*i +: 8];
  endfunction

  logic [BPW-1:0] par_q [DEPTH];
  logic [BPW-1:0] wpar;
  logic           perr_q;

  assign wpar = byte_par(wdata) ^ {BPW{inj}};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BPW; i++) begin
        if (stb[i]) par_q[idx][i] <= wpar[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= re && (byte_par(mem_q[idx]) != par_q[idx]);
  end

  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/sys_sram_apb.sv
// APB system SRAM slave: wait-state FSM, range check, registered response.
// Per-byte parity checking is compiled in with SYS_SRAM_PARITY_EN.
module sys_sram_apb
  import sys_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                               pclk,
  input  logic                               prst,
  input  logic [ADDR_WIDTH-1:0]              paddr,
  input  logic [DATA_WIDTH-1:0]              pdata,
  output logic [DATA_WIDTH-1:0]              prdata,
  input  logic                               psel,
  input  logic                               penable,
  input  logic                               pwrite,
  input  logic [bytes_per_word(DATA_WIDTH)-1:0] pstb,
`ifdef SYS_SRAM_PARITY_EN
  input  logic                               pinj,
`endif
  output logic                               pready,
  output logic                               perr
);
  localparam int SHIFT = addr_shift(DATA_WIDTH);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                pready_q, oor_q;
  logic [ADDR_WIDTH-1:0] widx;
  logic                in_range, commit;
  logic                bank_perr;

  assign widx     = paddr >> SHIFT;
  assign in_range = widx < ADDR_WIDTH'(DEPTH);

  // Commit happens on the edge that moves the FSM into RESP.
  always_comb begin
    commit = 1'b0;
    case (state_q)
      IDLE:    commit = psel && penable && (WAIT_STATES == 0);
      WAIT:    commit = psel && (wcnt_q == WCNT_W'(1));
      default: commit = 1'b0;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      pready_q <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      pready_q <= 1'b0;
      oor_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (psel && penable) begin
            wcnt_q <= WCNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state_q  <= RESP;
              pready_q <= 1'b1;
              oor_q    <= !in_range;
            end else begin
              state_q  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
          end else if (wcnt_q == WCNT_W'(1)) begin
            state_q  <= RESP;
            pready_q <= 1'b1;
            oor_q    <= !in_range;
            wcnt_q   <= '0;
          end else begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sram_bank #(.DW(DATA_WIDTH), .DEPTH(DEPTH), .IW(IW)) u_bank (
    .clk    (pclk),
    .rst    (prst),
    .we     (commit && pwrite && in_range),
    .re     (commit && !pwrite && in_range),
    .clr    (commit && !in_range),
    .idx    (widx[IW-1:0]),
    .wdata  (pdata),
    .stb    (pstb),
`ifdef SYS_SRAM_PARITY_EN
    .inj    (pinj),
`endif
    .rdata_o(prdata),
    .perr_o (bank_perr)
  );

  assign pready = pready_q;
  assign perr   = oor_q | bank_perr;

endmodule

// File: tb/tb_sys_sram_apb.sv
// Randomized bench for sys_sram_apb: two instances (0 and 3 wait states)
// checked every cycle against a transaction-level memory model.
module tb_sys_sram_apb;
  localparam int DEPTH = 64;
`ifdef SYS_SRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        prst = 1'b1;
  logic        psel[2], penable[2], pwrite[2], pinj[2];
  logic [31:0] paddr[2], pdata[2], prdata[2];
  logic [3:0]  pstb[2];
  logic        pready[2], perr[2];

  always #5 clk = ~clk;

  sys_sram_apb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .pclk(clk), .prst(prst), .paddr(paddr[0]), .pdata(pdata[0]), .prdata(prdata[0]),
    .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]), .pstb(pstb[0]),
`ifdef SYS_SRAM_PARITY_EN
    .pinj(pinj[0]),
`endif
    .pready(pready[0]), .perr(perr[0]));

  sys_sram_apb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u1 (
    .pclk(clk), .prst(prst), .paddr(paddr[1]), .pdata(pdata[1]), .prdata(prdata[1]),
    .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]), .pstb(pstb[1]),
`ifdef SYS_SRAM_PARITY_EN
    .pinj(pinj[1]),
`endif
    .pready(pready[1]), .perr(perr[1]));

  // Model: memory image, per-byte "parity corrupted" flags, expected response.
  logic [31:0] mdl  [2][DEPTH];
  logic [3:0]  mbad [2][DEPTH];
  int          exp_rdy[2]  = '{-1, -1};
  bit          exp_err[2]  = '{0, 0};
  logic [31:0] exp_prd[2]  = '{0, 0};
  logic [31:0] nprd[2]     = '{0, 0};
  bit          nv[2]       = '{0, 0};
  int          last_rdy[2] = '{-1, -1};
  bit          last_err[2] = '{0, 0};
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit er;
      er = (cyc == exp_rdy[k]);
      if (er && nv[k]) exp_prd[k] = nprd[k];
      if (pready[k] === 1'b1) begin
        last_rdy[k] = cyc;
        last_err[k] = perr[k];
      end
      chk($sformatf("pready%0d", k), 32'(pready[k]), 32'(er));
      chk($sformatf("perr%0d", k),   32'(perr[k]),   32'(er && exp_err[k]));
      chk($sformatf("prdata%0d", k), prdata[k],      exp_prd[k]);
    end
  end

  // One APB transfer (setup + access). abort_a >= 0 drops psel after that
  // many wait cycles (only meaningful while the transfer is still waiting).
  task automatic xfer(input int k, input bit wr, input int word, input logic [31:0] d,
                      input logic [3:0] stb, input bit inj, input int abort_a, output int st);
    int ws;
    bit oor;
    ws  = (k == 1) ? 3 : 0;
    oor = (word >= DEPTH);
    @(posedge clk); #1;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
    paddr[k] = 32'(word) * 4 + 32'($urandom_range(0, 3));
    pdata[k] = d; pstb[k] = stb; pinj[k] = inj;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    st = cyc;
    if (abort_a >= 0 && abort_a < ws) begin
      repeat (abort_a + 1) @(posedge clk);
      #1;
      psel[k] = 1'b0; penable[k] = 1'b0;
      repeat (2) @(posedge clk);
    end else begin
      exp_rdy[k] = st + ws + 1;
      if (oor) begin
        exp_err[k] = 1'b1; nv[k] = 1'b1; nprd[k] = '0;
      end else if (wr) begin
        exp_err[k] = 1'b0; nv[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (stb[i]) begin
            mdl[k][word][8*i +: 8] = d[8*i +: 8];
            mbad[k][word][i] = PAR && inj;
          end
        end
      end else begin
        exp_err[k] = PAR && (mbad[k][word] != 4'h0);
        nv[k] = 1'b1; nprd[k] = mdl[k][word];
      end
      repeat (ws + 2) @(posedge clk);
      #1;
      psel[k] = 1'b0; penable[k] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, old, k, w, ab;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 0; penable[i] = 0; pwrite[i] = 0; pinj[i] = 0;
      paddr[i] = 0; pdata[i] = 0; pstb[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_pready", 32'(pready[i]), 0);
      chk("rst_perr",   32'(perr[i]),   0);
      chk("rst_prdata", prdata[i],      0);
    end
    prst = 1'b0;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) xfer(i, 1, j, $urandom, 4'hF, 0, -1, st);

    // Read of a known word with zero wait states.
    xfer(0, 1, 4, 32'hCAFE0010, 4'hF, 0, -1, st);
    xfer(0, 0, 4, 0, 4'h0, 0, -1, st);
    chk("ws0_lat", 32'(last_rdy[0] - st), 1);
    chk("rd10", prdata[0], 32'hCAFE0010);

    // Byte-strobe merge on both instances.
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1, 16, 32'hAABBCCDD, 4'hF, 0, -1, st);
      xfer(i, 1, 16, 32'h11223344, 4'h5, 0, -1, st);
      xfer(i, 0, 16, 0, 4'h0, 0, -1, st);
      chk("rd40", prdata[i], 32'hAA22CC44);
    end
    xfer(0, 1, 17, 32'h01020304, 4'h0, 0, -1, st);
    xfer(0, 0, 17, 0, 4'h0, 0, -1, st);

    // Wait-state latency and abort.
    xfer(1, 1, 4, 32'h0BADBEEF, 4'hF, 0, -1, st);
    xfer(1, 0, 4, 0, 4'h0, 0, -1, st);
    chk("ws3_lat", 32'(last_rdy[1] - st), 4);
    xfer(1, 1, 8, 32'h5555AAAA, 4'hF, 0, 2, st);
    chk("abort_nordy", 32'(last_rdy[1] < st), 1);
    xfer(1, 0, 8, 0, 4'h0, 0, -1, st);

    // Out-of-range write and read; word 0 must not be aliased.
    xfer(0, 1, DEPTH, 32'hFFFFFFFF, 4'hF, 0, -1, st);
    chk("oor_wr_err", 32'(last_err[0]), 1);
    xfer(0, 0, DEPTH, 0, 4'h0, 0, -1, st);
    chk("oor_rd", prdata[0], 0);
    xfer(0, 0, 0, 0, 4'h0, 0, -1, st);

    // Reset in the middle of a waiting write.
    xfer(1, 0, 4, 0, 4'h0, 0, -1, st);
    old = mdl[1][32];
    @(posedge clk); #1;
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 32'h80;
    pdata[1] = 32'hDEADDEAD; pstb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1;
    @(posedge clk); #2;
    prst = 1'b1;
    exp_rdy[0] = -1; exp_rdy[1] = -1; exp_prd[0] = 0; exp_prd[1] = 0;
    #1;
    chk("arst_prdata", prdata[1], 0);
    chk("arst_pready", 32'(pready[1]), 0);
    psel[1] = 0; penable[1] = 0;
    @(posedge clk); #1;
    prst = 1'b0;
    xfer(1, 0, 32, 0, 4'h0, 0, -1, st);
    chk("rst_keep", prdata[1], old);

`ifdef SYS_SRAM_PARITY_EN
    xfer(0, 1, 0, 32'h12345678, 4'hF, 0, -1, st);
    xfer(0, 1, 0, 32'h12345678, 4'h2, 1, -1, st);
    chk("par_wr_ok", 32'(last_err[0]), 0);
    xfer(0, 0, 0, 0, 4'h0, 0, -1, st);
    chk("par_data", prdata[0], 32'h12345678);
    chk("par_err", 32'(last_err[0]), 1);
    xfer(0, 1, 0, 32'h12345678, 4'hF, 0, -1, st);
    xfer(0, 0, 0, 0, 4'h0, 0, -1, st);
    chk("par_clr", 32'(last_err[0]), 0);
`endif

    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom_range(0, 1));
      w  = int'($urandom_range(0, DEPTH + 3));
      ab = (k == 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      xfer(k, 1'($urandom_range(0, 1)), w, $urandom, 4'($urandom_range(0, 15)),
           PAR && ($urandom_range(0, 3) == 0), ab, st);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
